// File: rtl/fir_prog_pkg.sv
// Shared state encoding, width helpers and reset coefficient for the
// programmable multi-channel FIR filter.
package fir_prog_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      SCALE,
      HOLD
   } state_t;

   // All taps at 1 makes a freshly reset filter a plain moving sum.
   localparam int DEFAULT_COEF = 1;

   function automatic int calc_acc_w(input int b, input int c, input int h);
      return b + c + $clog2(h);
   endfunction

   function automatic int calc_k_w(input int h);
      return $clog2(h);
   endfunction

   function automatic int calc_ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_scale.sv
// Output scaler: arithmetic right shift with round-half-up, then saturation
// of the result to the signed output width.
module fir_scale #(
   parameter int bW   = 8,
   parameter int accW = 19,
   parameter int sW   = 5
) (
   input  logic signed [accW-1:0] acc,
   input  logic        [sW-1:0]   s,
   output logic signed [bW-1:0]   data,
   output logic                   sat
);

   localparam logic signed [accW:0] SAT_HI = {{(accW + 2 - bW){1'b0}}, {(bW - 1){1'b1}}};
   localparam logic signed [accW:0] SAT_LO = {{(accW + 2 - bW){1'b1}}, {(bW - 1){1'b0}}};

   logic        [accW:0] rnd;
   logic signed [accW:0] sum;
   logic signed [accW:0] r;

   // One extra bit of headroom so adding the rounding constant cannot wrap.
   always_comb begin
      rnd = '0;
      if (s != '0) begin
         rnd = (accW + 1)'(1) << (s - sW'(1));
      end
   end

   assign sum = $signed({acc[accW-1], acc}) + $signed(rnd);
   assign r   = sum >>> s;

   always_comb begin
      data = r[bW-1:0];
      sat  = 1'b0;
      if (r > SAT_HI) begin
         data = SAT_HI[bW-1:0];
         sat  = 1'b1;
      end else if (r < SAT_LO) begin
         data = SAT_LO[bW-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/fir_prog.sv
// Programmable multi-channel signed FIR: per-channel delay lines feeding one
// shared multiply-accumulate that processes a single tap per cycle.
module fir_prog
   import fir_prog_pkg::*;
#(
   parameter int  bW   = 8,
   parameter int  cW   = 8,
   parameter int  hC   = 5,
   parameter int  nCh  = 2,
   localparam int chW  = calc_ch_w(nCh),
   localparam int kW   = calc_k_w(hC),
   localparam int accW = calc_acc_w(bW, cW, hC),
   localparam int sW   = $clog2(accW)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [chW-1:0]       in_ch,
   input  logic signed [bW-1:0] in_data,
   input  logic                 coef_we,
   input  logic [kW-1:0]        coef_addr,
   input  logic signed [cW-1:0] coef_data,
   input  logic [sW-1:0]        shift,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [chW-1:0]       out_ch,
   output logic signed [bW-1:0] out_data,
   output logic                 out_sat
);

   state_t state, next_state;

   logic signed [bW-1:0]      dly  [nCh][hC];
   logic signed [cW-1:0]      coef [hC];
   logic signed [accW-1:0]    acc;
   logic        [kW-1:0]      k;
   logic        [chW-1:0]     ch;
   logic signed [bW+cW-1:0]   prod;
   logic signed [accW-1:0]    prod_ext;
   logic        [sW-1:0]      s;
   logic signed [bW-1:0]      scaled;
   logic                      scaled_sat;
   logic                      ch_ok;
   logic                      addr_ok;
   logic                      accept;
   logic                      coef_wr;
   logic                      last_tap;

   // Range checks collapse to constants when the field width exactly covers the count.
   if (nCh == (1 << chW)) begin : g_ch_full
      assign ch_ok = 1'b1;
   end else begin : g_ch_part
      assign ch_ok = (in_ch < chW'(nCh));
   end

   if (hC == (1 << kW)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (coef_addr < kW'(hC));
   end

   assign in_ready  = (state == IDLE) && rst;
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign coef_wr   = coef_we && addr_ok && (state == IDLE);
   assign last_tap  = (k == kW'(hC - 1));

   assign prod     = (bW + cW)'(coef[k]) * (bW + cW)'(dly[ch][k]);
   assign prod_ext = {{(accW - bW - cW){prod[bW+cW-1]}}, prod};
   assign s        = (shift > sW'(accW - 1)) ? sW'(accW - 1) : shift;

   fir_scale #(
      .bW   (bW),
      .accW (accW),
      .sW   (sW)
   ) u_scale (
      .acc  (acc),
      .s    (s),
      .data (scaled),
      .sat  (scaled_sat)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A sample on a nonexistent channel is consumed but never enters the MAC.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid && ch_ok) next_state = MAC;
         MAC:     if (last_tap) next_state = SCALE;
         SCALE:   next_state = HOLD;
         HOLD:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         k   <= '0;
         ch  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && ch_ok) begin
                  acc <= '0;
                  k   <= '0;
                  ch  <= in_ch;
               end
            end
            MAC: begin
               acc <= acc + prod_ext;
               k   <= k + kW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < nCh; c++) begin
            for (int t = 0; t < hC; t++) begin
               dly[c][t] <= '0;
            end
         end
      end else if (accept && ch_ok) begin
         for (int c = 0; c < nCh; c++) begin
            if (in_ch == chW'(c)) begin
               dly[c][0] <= in_data;
               for (int t = 1; t < hC; t++) begin
                  dly[c][t] <= dly[c][t-1];
               end
            end
         end
      end
   end

   // Coefficient writes land on the accept edge, so the MAC already sees them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < hC; t++) begin
            coef[t] <= cW'(DEFAULT_COEF);
         end
      end else if (coef_wr) begin
         for (int t = 0; t < hC; t++) begin
            if (coef_addr == kW'(t)) begin
               coef[t] <= coef_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= '0;
         out_sat  <= 1'b0;
         out_ch   <= '0;
      end else if (state == SCALE) begin
         out_data <= scaled;
         out_sat  <= scaled_sat;
         out_ch   <= ch;
      end
   end

endmodule

// File: tb/tb_fir_prog.sv
// Self-checking bench for fir_prog: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the filter.
module tb_fir_prog;
   import fir_prog_pkg::*;

   localparam int BW   = 8;
   localparam int CW   = 8;
   localparam int HC   = 5;
   localparam int NCH  = 2;
   localparam int CHW  = calc_ch_w(NCH);
   localparam int KW   = calc_k_w(HC);
   localparam int ACCW = calc_acc_w(BW, CW, HC);
   localparam int SW   = $clog2(ACCW);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [CHW-1:0] in_ch = '0;
   logic [BW-1:0]  in_data = '0;
   logic           coef_we = 1'b0;
   logic [KW-1:0]  coef_addr = '0;
   logic [CW-1:0]  coef_data = '0;
   logic [SW-1:0]  shift = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [CHW-1:0] out_ch;
   logic [BW-1:0]  out_data;
   logic           out_sat;

   int checks = 0;
   int errors = 0;

   int m_dly  [NCH][HC];
   int m_coef [HC];

   fir_prog #(
      .bW  (BW),
      .cW  (CW),
      .hC  (HC),
      .nCh (NCH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .shift     (shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++)
         for (int t = 0; t < HC; t++)
            m_dly[c][t] = 0;
      for (int t = 0; t < HC; t++)
         m_coef[t] = 1;
   endtask

   task automatic model_push(input int ch, input int d);
      for (int t = HC - 1; t > 0; t--)
         m_dly[ch][t] = m_dly[ch][t-1];
      m_dly[ch][0] = d;
   endtask

   // y = sum c[k]*d[k], divided by 2^s rounding half up, then clipped.
   task automatic model_expect(input int ch, input int sh, output int y, output bit sat);
      longint acc;
      longint r;
      int     s;
      acc = 0;
      for (int t = 0; t < HC; t++)
         acc += longint'(m_coef[t]) * longint'(m_dly[ch][t]);
      s = (sh > ACCW - 1) ? ACCW - 1 : sh;
      r = (s > 0) ? ((acc + (longint'(1) << (s - 1))) >>> s) : acc;
      sat = 1'b0;
      if (r > 127) begin
         r = 127;
         sat = 1'b1;
      end else if (r < -128) begin
         r = -128;
         sat = 1'b1;
      end
      y = int'(r);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic write_coef(input int addr, input int val);
      coef_we   = 1'b1;
      coef_addr = KW'(addr);
      coef_data = CW'(val);
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   // Drives one sample and waits (bounded) for its result; assumes out_ready high.
   task automatic send_sample(input int ch, input int d, output int got_d, output int got_ch,
                              output bit got_sat, output bit timeout);
      int n;
      got_d = 0;
      got_ch = 0;
      got_sat = 1'b0;
      timeout = 1'b0;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         timeout = 1'b1;
         return;
      end
      in_valid = 1'b1;
      in_ch    = CHW'(ch);
      in_data  = BW'(d);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         timeout = 1'b1;
         return;
      end
      got_d   = int'($signed(out_data));
      got_ch  = int'(out_ch);
      got_sat = out_sat;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int d, c;
      bit st, to;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || out_sat !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: ready=%b valid=%b data=%0d ch=%0d sat=%b, required all 0",
                  in_ready, out_valid, out_data, out_ch, out_sat);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
      shift = SW'(3);
      for (int i = 0; i < 5; i++) begin
         send_sample(0, 8, d, c, st, to);
         checks++;
         if (to || d !== i + 1 || st !== 1'b0) begin
            errors++;
            $display("[TB] FAIL moving_sum[%0d]: got %0d sat=%b timeout=%b, required %0d sat=0",
                     i, d, st, to, i + 1);
         end
      end
   endtask

   task automatic test_coef_sat();
      int ins [3] = '{50, 100, -100};
      int exp [3] = '{100, 127, -128};
      bit exs [3] = '{1'b0, 1'b1, 1'b1};
      int d, c;
      bit st, to;
      write_coef(0, 2);
      for (int t = 1; t < HC; t++)
         write_coef(t, 0);
      shift = '0;
      for (int i = 0; i < 3; i++) begin
         send_sample(0, ins[i], d, c, st, to);
         checks++;
         if (to || d !== exp[i] || st !== exs[i]) begin
            errors++;
            $display("[TB] FAIL coef_sat[%0d]: got %0d sat=%b, required %0d sat=%b",
                     i, d, st, exp[i], exs[i]);
         end
      end
   endtask

   task automatic test_channels();
      int d, c;
      bit st, to;
      apply_reset();
      shift = '0;
      for (int i = 0; i < 6; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            send_sample(ch, (ch + 1) * 10, d, c, st, to);
            checks++;
            if (to || d !== (ch + 1) * 10 * ((i < 5) ? i + 1 : 5) || c !== ch) begin
               errors++;
               $display("[TB] FAIL channels[%0d] ch%0d: got %0d on ch %0d, required %0d on ch %0d",
                        i, ch, d, c, (ch + 1) * 10 * ((i < 5) ? i + 1 : 5), ch);
            end
         end
      end
   endtask

   task automatic test_rounding();
      int ins [3] = '{6, 5, -6};
      int exp [3] = '{2, 1, -1};
      int d, c;
      bit st, to;
      write_coef(0, 1);
      for (int t = 1; t < HC; t++)
         write_coef(t, 0);
      shift = SW'(2);
      for (int i = 0; i < 3; i++) begin
         send_sample(0, ins[i], d, c, st, to);
         checks++;
         if (to || d !== exp[i]) begin
            errors++;
            $display("[TB] FAIL rounding[%0d]: got %0d, required %0d", i, d, exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int  y, d, c, n;
      bit  ys, st, to;
      logic [BW-1:0] held;
      apply_reset();
      shift = SW'(1);
      out_ready = 1'b0;
      model_push(1, 37);
      model_expect(1, 1, y, ys);
      in_valid = 1'b1;
      in_ch    = CHW'(1);
      in_data  = BW'(37);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      held = out_data;
      checks++;
      if (!out_valid || int'($signed(held)) !== y) begin
         errors++;
         $display("[TB] FAIL hold_first: valid=%b data=%0d, required valid=1 data=%0d",
                  out_valid, $signed(held), y);
      end
      for (int i = 0; i < 10; i++) begin
         coef_we   = (i == 3);
         coef_addr = '0;
         coef_data = CW'(77);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_stable[%0d]: valid=%b data=%0d ready=%b, required 1/%0d/0",
                     i, out_valid, $signed(out_data), in_ready, $signed(held));
         end
      end
      coef_we = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_release: valid=%b ready=%b, required 0/1", out_valid, in_ready);
      end
      model_push(1, 37);
      model_expect(1, 1, y, ys);
      send_sample(1, 37, d, c, st, to);
      checks++;
      if (to || d !== y || st !== ys) begin
         errors++;
         $display("[TB] FAIL blocked_write: got %0d sat=%b, required %0d sat=%b", d, st, y, ys);
      end
   endtask

   task automatic test_write_with_accept();
      int y, n;
      bit ys;
      shift = '0;
      m_coef[0] = 3;
      model_push(0, 7);
      model_expect(0, 0, y, ys);
      coef_we   = 1'b1;
      coef_addr = '0;
      coef_data = CW'(3);
      in_valid  = 1'b1;
      in_ch     = '0;
      in_data   = BW'(7);
      @(negedge clk);
      coef_we  = 1'b0;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!out_valid || int'($signed(out_data)) !== y) begin
         errors++;
         $display("[TB] FAIL write_with_accept: valid=%b data=%0d, required %0d",
                  out_valid, $signed(out_data), y);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int y, d, c, ch, smp, sh, addr, val;
      bit ys, st, to;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            addr = $urandom_range(0, 7);
            val  = $urandom_range(0, 255) - 128;
            write_coef(addr, val);
            if (addr < HC)
               m_coef[addr] = val;
         end
         sh  = $urandom_range(0, 31);
         ch  = $urandom_range(0, NCH - 1);
         smp = $urandom_range(0, 255) - 128;
         shift = SW'(sh);
         model_push(ch, smp);
         model_expect(ch, sh, y, ys);
         send_sample(ch, smp, d, c, st, to);
         checks++;
         if (to || d !== y || st !== ys || c !== ch) begin
            errors++;
            $display("[TB] FAIL random[%0d]: got %0d sat=%b ch=%0d, required %0d sat=%b ch=%0d",
                     i, d, st, c, y, ys, ch);
         end
      end
   endtask

   task automatic test_async_reset();
      int d, c;
      bit st, to;
      shift = SW'(3);
      in_valid = 1'b1;
      in_ch    = '0;
      in_data  = BW'(100);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut.state !== IDLE || out_data !== '0) begin
         errors++;
         $display("[TB] FAIL async_abort: valid=%b ready=%b state=%0d data=%0d, required 0/0/IDLE/0",
                  out_valid, in_ready, dut.state, out_data);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      send_sample(0, 8, d, c, st, to);
      checks++;
      if (to || d !== 1) begin
         errors++;
         $display("[TB] FAIL post_reset: got %0d, required 1", d);
      end
   endtask

   initial begin
      test_reset();
      test_coef_sat();
      test_channels();
      test_rounding();
      test_backpressure();
      test_write_with_accept();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
